// File: rtl/vga_frame_scanout.sv
// 320x240x6 frame buffer with a pixel write port, scanned out as 640x480@60Hz VGA
// with 2x2 pixel doubling, a pixel-enable from a 50 MHz clock and a per-frame tick.
module vga_frame_scanout #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [8:0] wr_x,
    input  logic [7:0] wr_y,
    input  logic [5:0] wr_colour,
    input  logic       wr_enable,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       vga_sync_n,
    output logic       vga_clk,
    output logic       frame_tick
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int FB_DEPTH = 320 * 240;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] V_VIS_LAST = 10'(V_VISIBLE - 1);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic       pix_en_q, pix_en_d;
    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic       frame_tick_q, frame_tick_d;

    logic       vis1_q, vis1_d;
    logic       hs1_q, hs1_d;
    logic       vs1_q, vs1_d;

    logic [7:0] vga_r_q, vga_r_d;
    logic [7:0] vga_g_q, vga_g_d;
    logic [7:0] vga_b_q, vga_b_d;
    logic       vga_hs_q, vga_hs_d;
    logic       vga_vs_q, vga_vs_d;
    logic       vga_blank_n_q, vga_blank_n_d;

    logic [5:0]  fb_mem [0:FB_DEPTH-1];
    logic [5:0]  rd_data_q;
    logic [16:0] rd_addr;
    logic [16:0] wr_addr;
    logic        wr_ok;
    logic [8:0]  rd_x;
    logic [8:0]  rd_y;

    // Counters advance only on pixel-enable clocks; the tick marks entry into vertical blank.
    always_comb begin
        pix_en_d     = ~pix_en_q;
        h_cnt_d      = h_cnt_q;
        v_cnt_d      = v_cnt_q;
        frame_tick_d = 1'b0;
        if (pix_en_q) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
                if (v_cnt_q == V_VIS_LAST) begin
                    frame_tick_d = 1'b1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    always_comb begin
        vis1_d = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        hs1_d  = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
        vs1_d  = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
        rd_x   = h_cnt_q[9:1];
        rd_y   = v_cnt_q[9:1];
        // Outside the visible area the address is parked at 0 to stay inside the buffer.
        rd_addr = vis1_d ? ((17'(rd_y) << 8) + (17'(rd_y) << 6) + 17'(rd_x)) : '0;
        wr_ok   = wr_enable && (wr_x < 9'd320) && (wr_y < 8'd240);
        wr_addr = (17'(wr_y) << 8) + (17'(wr_y) << 6) + 17'(wr_x);
    end

    // Frame buffer: no reset so it maps onto block RAM; read-before-write on collisions.
    always_ff @(posedge clock) begin
        if (wr_ok) begin
            fb_mem[wr_addr] <= wr_colour;
        end
        rd_data_q <= fb_mem[rd_addr];
    end

    always_comb begin
        vga_r_d       = vis1_q ? {4{rd_data_q[5:4]}} : 8'h00;
        vga_g_d       = vis1_q ? {4{rd_data_q[3:2]}} : 8'h00;
        vga_b_d       = vis1_q ? {4{rd_data_q[1:0]}} : 8'h00;
        vga_hs_d      = hs1_q;
        vga_vs_d      = vs1_q;
        vga_blank_n_d = vis1_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pix_en_q      <= 1'b0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            frame_tick_q  <= 1'b0;
            vis1_q        <= 1'b0;
            hs1_q         <= 1'b1;
            vs1_q         <= 1'b1;
            vga_r_q       <= '0;
            vga_g_q       <= '0;
            vga_b_q       <= '0;
            vga_hs_q      <= 1'b1;
            vga_vs_q      <= 1'b1;
            vga_blank_n_q <= 1'b0;
        end else begin
            pix_en_q      <= pix_en_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            frame_tick_q  <= frame_tick_d;
            vis1_q        <= vis1_d;
            hs1_q         <= hs1_d;
            vs1_q         <= vs1_d;
            vga_r_q       <= vga_r_d;
            vga_g_q       <= vga_g_d;
            vga_b_q       <= vga_b_d;
            vga_hs_q      <= vga_hs_d;
            vga_vs_q      <= vga_vs_d;
            vga_blank_n_q <= vga_blank_n_d;
        end
    end

    assign vga_r       = vga_r_q;
    assign vga_g       = vga_g_q;
    assign vga_b       = vga_b_q;
    assign vga_hs      = vga_hs_q;
    assign vga_vs      = vga_vs_q;
    assign vga_blank_n = vga_blank_n_q;
    assign vga_sync_n  = 1'b0;
    assign vga_clk     = pix_en_q;
    assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_vga_frame_scanout.sv
// Directed bench: a full-timing instance for line-level checks and a shrunken-timing
// instance (24x12 pixel-clock frame, 8x4 buffer pixels visible) for frame-level checks.
module tb_vga_frame_scanout;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic [8:0] wr_x;
    logic [7:0] wr_y;
    logic [5:0] wr_colour;
    logic       wr_enable;

    logic [7:0] f_r, f_g, f_b, s_r, s_g, s_b;
    logic       f_hs, f_vs, f_blank, f_sync, f_clk, f_tick;
    logic       s_hs, s_vs, s_blank, s_sync, s_clk, s_tick;

    vga_frame_scanout u_full (
        .clock(clock), .reset(reset),
        .wr_x(wr_x), .wr_y(wr_y), .wr_colour(wr_colour), .wr_enable(wr_enable),
        .vga_r(f_r), .vga_g(f_g), .vga_b(f_b), .vga_hs(f_hs), .vga_vs(f_vs),
        .vga_blank_n(f_blank), .vga_sync_n(f_sync), .vga_clk(f_clk), .frame_tick(f_tick)
    );

    vga_frame_scanout #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
        .V_VISIBLE(8), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) u_small (
        .clock(clock), .reset(reset),
        .wr_x(wr_x), .wr_y(wr_y), .wr_colour(wr_colour), .wr_enable(wr_enable),
        .vga_r(s_r), .vga_g(s_g), .vga_b(s_b), .vga_hs(s_hs), .vga_vs(s_vs),
        .vga_blank_n(s_blank), .vga_sync_n(s_sync), .vga_clk(s_clk), .frame_tick(s_tick)
    );

    int total = 0;
    int bad   = 0;
    int k     = 0;   // posedges since the last reset release

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
        k++;
    endtask

    task automatic wr(input logic [8:0] x, input logic [7:0] y, input logic [5:0] c);
        wr_x = x; wr_y = y; wr_colour = c; wr_enable = 1'b1;
        step();
        wr_enable = 1'b0;
    endtask

    // {r,g,b,hs,vs,blank_n,sync_n,clk,tick} reset value
    task automatic chk_reset_vals(input string tag);
        chk({tag, "_full"}, {f_r, f_g, f_b, f_hs, f_vs, f_blank, f_sync, f_clk, f_tick},
            {24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        chk({tag, "_small"}, {s_r, s_g, s_b, s_hs, s_vs, s_blank, s_sync, s_clk, s_tick},
            {24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        step();
        reset = 1'b1;
        k = 0;
    endtask

    int   f_fall0, f_fall1, f_hs_low, f_blank_hi;
    int   s_tick0, s_tick1, s_tick_cnt, s_vs_fall, s_vs_low;
    logic f_hs_prev, s_vs_prev;

    initial begin
        reset = 1'b0; wr_x = '0; wr_y = '0; wr_colour = '0; wr_enable = 1'b0;
        repeat (3) @(negedge clock);
        chk_reset_vals("reset_hold");

        reset = 1'b1;
        k = 0;
        step();
        chk("pix_en_first", {31'h0, f_clk}, 32'h1);
        chk("out_k1_still_reset", {f_hs, f_blank, f_r}, {1'b1, 1'b0, 8'h00});

        // Prefill the pixels that are checked, then out-of-range writes, then the corners.
        wr(9'd1, 8'd0, 6'h00);
        wr(9'd319, 8'd0, 6'h00);
        wr(9'd0, 8'd1, 6'h00);
        wr(9'd320, 8'd0, 6'h3F);
        wr(9'd0, 8'd240, 6'h3F);
        wr(9'd0, 8'd0, 6'h30);
        wr(9'd319, 8'd239, 6'h03);
        wr(9'd7, 8'd3, 6'h03);

        // The buffer survives reset; scanout restarts at h=0, v=0.
        reset_pulse();
        f_fall0 = -1; f_fall1 = -1; f_hs_low = 0; f_blank_hi = 0; f_hs_prev = 1'b1;
        s_tick0 = -1; s_tick1 = -1; s_tick_cnt = 0; s_vs_fall = -1; s_vs_low = 0; s_vs_prev = 1'b1;
        for (int i = 0; i < 3300; i++) begin
            step();
            if (f_hs_prev && !f_hs) begin
                if (f_fall0 < 0) f_fall0 = k;
                else if (f_fall1 < 0) f_fall1 = k;
            end
            f_hs_prev = f_hs;
            if (k <= 1600) begin
                if (!f_hs) f_hs_low++;
                if (f_blank) f_blank_hi++;
            end
            if (k <= 1000 && s_tick) begin
                s_tick_cnt++;
                if (s_tick0 < 0) s_tick0 = k;
                else if (s_tick1 < 0) s_tick1 = k;
            end
            if (s_vs_prev && !s_vs && s_vs_fall < 0) s_vs_fall = k;
            s_vs_prev = s_vs;
            if (k <= 576 && !s_vs) s_vs_low++;

            // Buffer pixel (x,y) first appears at k = 2 + 2*(2*y*H_TOTAL + 2*x).
            case (k)
                2:    begin
                          chk("full_px00_first", {f_r, f_g, f_b, f_blank}, {8'hFF, 8'h00, 8'h00, 1'b1});
                          chk("small_px00_first", {s_r, s_g, s_b}, {8'hFF, 8'h00, 8'h00});
                      end
                5:    chk("full_px00_last", {24'h0, f_r}, 32'hFF);
                6:    chk("full_px10_zero", {f_r, f_g, f_b}, 24'h0);
                50:   chk("small_px00_line1", {s_r, s_g, s_b}, {8'hFF, 8'h00, 8'h00});
                98:   chk("small_oor_x_dropped", {s_r, s_g, s_b}, 24'h0);
                318:  chk("small_corner_l6_first", {s_r, s_g, s_b, s_blank}, {8'h00, 8'h00, 8'hFF, 1'b1});
                321:  chk("small_corner_l6_last", {s_r, s_g, s_b}, {8'h00, 8'h00, 8'hFF});
                322:  chk("small_after_visible", {s_r, s_g, s_b, s_blank}, {24'h0, 1'b0});
                366:  chk("small_corner_l7_first", {s_r, s_g, s_b}, {8'h00, 8'h00, 8'hFF});
                369:  chk("small_corner_l7_last", {s_r, s_g, s_b}, {8'h00, 8'h00, 8'hFF});
                1279: chk("full_px319_0_zero", {f_r, f_g, f_b, f_blank}, {24'h0, 1'b1});
                1282: chk("full_blank_rgb_forced0", {f_r, f_g, f_b, f_blank}, {24'h0, 1'b0});
                1602: chk("full_px00_line1", {f_r, f_g, f_b}, {8'hFF, 8'h00, 8'h00});
                3202: chk("full_oor_x_dropped", {f_r, f_g, f_b}, 24'h0);
                default: ;
            endcase
        end

        // hs low for h 656..751, registered two clocks after the counter state.
        chk("hs_first_fall", f_fall0, 1314);
        chk("hs_line_period", f_fall1 - f_fall0, 1600);
        chk("hs_low_clocks", f_hs_low, 192);
        chk("blank_hi_clocks", f_blank_hi, 1280);
        chk("tick_first", s_tick0, 384);
        chk("tick_period", s_tick1 - s_tick0, 576);
        chk("tick_count", s_tick_cnt, 2);
        chk("vs_first_fall", s_vs_fall, 434);
        chk("vs_low_clocks", s_vs_low, 96);

        // Mid-line reset at line 1, h around 400: outputs drop immediately.
        reset_pulse();
        while (k < 2400) step();
        chk("pre_reset_visible", {31'h0, f_blank}, 32'h1);
        reset = 1'b0;
        #1;
        chk_reset_vals("async_reset");
        @(negedge clock);
        reset = 1'b1;
        k = 0;
        while (f_hs && k < 3000) step();
        chk("hs_fall_after_midreset", k, 1314);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
